mem_ctrl: RTL and testbench

//   Multi-cycle memory subsystem downstream of the datapath's MAR/MDR. It latches a

---
 rtl/mem_ctrl.sv | 100 ++++++++++
 tb/tb_mem_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Multi-cycle word memory behind MAR/MDR. A request is latched in IDLE, optionally
// delayed by WAIT_STATES cycles, performed in ACCESS, and acknowledged by a one-cycle
// done pulse (with err on fault) that appears as the controller re-enters IDLE.
module mem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    op_wr_q;
  logic                    fault_q;

  logic [DATA_WIDTH-1:0]   ram [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]   idx;
  logic                    addr_fault;

  assign idx        = addr_q[ADDR_WIDTH-1:0];
  assign addr_fault = |addr_q[31:ADDR_WIDTH];

  // RAM write port; clr on the ACCESS edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!clr && state_q == ACCESS && op_wr_q && !addr_fault)
      ram[idx] <= wdata_q;
  end

  // Request sequencer with registered busy/done/err/data_out.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_read ^ mem_write) begin
            addr_q  <= address;
            wdata_q <= data_in;
            op_wr_q <= mem_write;
            fault_q <= 1'b0;
            busy    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= ACCESS;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WS_M1;
            end
          end else if (mem_read && mem_write) begin
            // Illegal request: nothing latched, just report a fault.
            fault_q <= 1'b1;
            busy    <= 1'b1;
            state_q <= DONE;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ACCESS: begin
          fault_q <= addr_fault;
          if (!op_wr_q)
            data_out <= addr_fault ? '0 : ram[idx];
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          err     <= fault_q;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a driver issues requests and pushes the predicted
// completion (cycle, err, data_out) while a monitor pops on every done pulse.
module tb_mem_ctrl;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        clr, mem_read, mem_write;
  logic [31:0] address, data_in, data_out;
  logic        busy, done, err;

  logic        clr0, rd0, wr0;
  logic [31:0] addr0, din0, dout0;
  logic        busy0, done0, err0;

  always #5 clk = ~clk;

  mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(WS)) dut (
    .clk(clk), .clr(clr), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .err(err));

  mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr0), .mem_read(rd0), .mem_write(wr0),
    .address(addr0), .data_in(din0), .data_out(dout0),
    .busy(busy0), .done(done0), .err(err0));

  typedef struct {int due; logic err; logic [31:0] data;} exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;

  // reference model
  logic [31:0] mem_m [512];
  logic [8:0]  written[$];
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("data_out", data_out, e.data);
        chk("busy_at_done", {31'b0, busy}, 32'h0);
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    logic flt;
    mem_read = rd; mem_write = wr; address = a; data_in = d;
    flt = |a[31:9];
    if (rd && wr) begin
      lat = 1;
      e.err = 1'b1;
    end else begin
      lat = WS + 2;
      e.err = flt;
      if (wr && !flt) begin
        mem_m[a[8:0]] = d;
        written.push_back(a[8:0]);
      end
      if (rd) last_rd = flt ? 32'h0 : mem_m[a[8:0]];
    end
    e.data = last_rd;
    e.due  = cyc + 1 + lat;
    exp_q.push_back(e);
    @(negedge clk);
    chk("busy_after_req", {31'b0, busy}, 32'h1);
    // garbage on all request inputs while busy must be ignored
    repeat (lat) begin
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      address = $urandom; data_in = $urandom;
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    clr = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; data_in = '0;
    clr0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_data_out", data_out, 32'h0);
    clr = 1'b0; clr0 = 1'b0;

    // zero-wait-state instance: write then read, with exact cycle timing
    wr0 = 1'b1; addr0 = 32'h3; din0 = 32'hCAFE_F00D;
    @(negedge clk); wr0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ws0_wr_done", {31'b0, done0}, 32'h1);
    rd0 = 1'b1; addr0 = 32'h3;
    @(negedge clk); rd0 = 1'b0;
    chk("ws0_busy_c1", {31'b0, busy0}, 32'h1);
    chk("ws0_done_c1", {31'b0, done0}, 32'h0);
    @(negedge clk);
    chk("ws0_busy_c2", {31'b0, busy0}, 32'h1);
    chk("ws0_done_c2", {31'b0, done0}, 32'h0);
    @(negedge clk);
    chk("ws0_busy_c3", {31'b0, busy0}, 32'h0);
    chk("ws0_done_c3", {31'b0, done0}, 32'h1);
    chk("ws0_err", {31'b0, err0}, 32'h0);
    chk("ws0_data", dout0, 32'hCAFE_F00D);

    // directed cases through the scoreboard
    do_req(1'b0, 1'b1, 32'h12, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h12, 32'h0);
    do_req(1'b0, 1'b1, 32'h0, 32'h1111_2222);
    do_req(1'b0, 1'b1, 32'h200, 32'h9999_9999);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h200, 32'h0);
    do_req(1'b1, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 1'b1, 32'h12, 32'h5555_5555);
    do_req(1'b1, 1'b0, 32'h12, 32'h0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        a = {23'b0, 9'($urandom)};
        do_req(1'b0, 1'b1, a, $urandom);
      end else if (r < 75 && written.size() > 0) begin
        a = {23'b0, written[$urandom_range(0, written.size() - 1)]};
        do_req(1'b1, 1'b0, a, $urandom);
      end else if (r < 90) begin
        a = $urandom | 32'h200;
        do_req(r[0], ~r[0], a, $urandom);
      end else begin
        do_req(1'b1, 1'b1, $urandom, $urandom);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // clr in the ACCESS cycle aborts a write
    do_req(1'b0, 1'b1, 32'h5, 32'hA5A5_0005);
    mem_write = 1'b1; address = 32'h5; data_in = 32'h1234_5678;
    @(negedge clk); mem_write = 1'b0;
    chk("abort_busy_wait", {31'b0, busy}, 32'h1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    last_rd = 32'h0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_data_out", data_out, 32'h0);
    repeat (4) @(negedge clk);
    do_req(1'b1, 1'b0, 32'h5, 32'h0);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      chk("scoreboard_drained", exp_q.size(), 32'h0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
